// File: rtl/entrada_tempo.sv
// Keypad time-entry and timer-load controller: collects MM:SS digits in a BCD
// buffer, validates on start, and drives load/enable of the down-counter chain.
module entrada_tempo (
    input  logic        clk,
    input  logic        clr,
    input  logic [9:0]  keypad,
    input  logic        start,
    input  logic        cancel,
    input  logic        door_closed,
    input  logic        timer_zero,
    output logic [15:0] data,
    output logic        loadn,
    output logic        en,
    output logic [2:0]  digits,
    output logic        done,
    output logic        error
);

    typedef enum logic [1:0] {ENTRY, LOAD, RUNNING, CLEAR} state_t;

    state_t      state_reg;
    logic [9:0]  key_q_reg;
    logic [15:0] data_reg;
    logic        loadn_reg;
    logic        en_reg;
    logic [2:0]  digits_reg;
    logic        done_reg;
    logic        error_reg;

    logic [3:0]  key_terms [10];
    logic [3:0]  key_code;
    logic        key_onehot;
    logic        key_hit;
    logic        sec_tens_bad;

    // Each held key contributes its own index; only meaningful when one-hot.
    generate
        for (genvar gi = 0; gi < 10; gi++) begin : g_key_enc
            assign key_terms[gi] = keypad[gi] ? 4'(gi) : 4'd0;
        end
    endgenerate

    always_comb begin
        key_code = 4'd0;
        for (int i = 0; i < 10; i++) begin
            key_code = key_code | key_terms[i];
        end
    end

    assign key_onehot   = (keypad != 10'd0) && ((keypad & (keypad - 10'd1)) == 10'd0);
    assign key_hit      = key_onehot && (key_q_reg == 10'd0);
    assign sec_tens_bad = data_reg[7:4] > 4'd5;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_reg  <= ENTRY;
            key_q_reg  <= 10'd0;
            data_reg   <= 16'd0;
            loadn_reg  <= 1'b1;
            en_reg     <= 1'b0;
            digits_reg <= 3'd0;
            done_reg   <= 1'b0;
            error_reg  <= 1'b0;
        end else begin
            key_q_reg <= keypad;
            done_reg  <= 1'b0;
            error_reg <= 1'b0;
            case (state_reg)
                ENTRY: begin
                    loadn_reg <= 1'b1;
                    en_reg    <= 1'b0;
                    if (cancel) begin
                        data_reg   <= 16'd0;
                        digits_reg <= 3'd0;
                    end else if (start) begin
                        // An empty buffer or open door makes start a no-op.
                        if (door_closed && (data_reg != 16'd0)) begin
                            if (sec_tens_bad) begin
                                error_reg <= 1'b1;
                            end else begin
                                state_reg <= LOAD;
                                loadn_reg <= 1'b0;
                            end
                        end
                    end else if (key_hit && (digits_reg < 3'd4)) begin
                        data_reg   <= {data_reg[11:0], key_code};
                        digits_reg <= digits_reg + 3'd1;
                    end
                end
                LOAD: begin
                    state_reg <= RUNNING;
                    loadn_reg <= 1'b1;
                    en_reg    <= door_closed;
                end
                RUNNING: begin
                    if (cancel) begin
                        state_reg  <= CLEAR;
                        data_reg   <= 16'd0;
                        digits_reg <= 3'd0;
                        loadn_reg  <= 1'b0;
                        en_reg     <= 1'b0;
                    end else if (timer_zero) begin
                        state_reg  <= ENTRY;
                        data_reg   <= 16'd0;
                        digits_reg <= 3'd0;
                        done_reg   <= 1'b1;
                        en_reg     <= 1'b0;
                    end else begin
                        en_reg <= door_closed;
                    end
                end
                CLEAR: begin
                    state_reg <= ENTRY;
                    loadn_reg <= 1'b1;
                    en_reg    <= 1'b0;
                end
                default: begin
                    state_reg <= ENTRY;
                    loadn_reg <= 1'b1;
                    en_reg    <= 1'b0;
                end
            endcase
        end
    end

    assign data   = data_reg;
    assign loadn  = loadn_reg;
    assign en     = en_reg;
    assign digits = digits_reg;
    assign done   = done_reg;
    assign error  = error_reg;

endmodule

// File: doc/entrada_tempo.md
# entrada_tempo

Keypad time-entry and timer-load controller for the microwave timer. It captures decimal key presses into a 4-digit BCD buffer (MM:SS), validates the entry on start, and drives the load/enable side of the mm:ss down-counter chain: a one-cycle active-low load pulse, then a count enable. It also watches the chain's all-zero indication to end a cook cycle. It sits between the keypad/panel logic and the timer counter chain.

## Interface
- No parameters.
- clk  input  1  system clock, rising edge.
- clr  input  1  asynchronous reset, active-high.
- keypad  input  10  level inputs, bit k = digit key k held.
- start  input  1  start request, sampled each edge.
- cancel  input  1  cancel request, sampled each edge.
- door_closed  input  1  1 = door closed.
- timer_zero  input  1  1 = all timer digits are 0 (from the counter chain).
- data  output  16  BCD buffer {min_tens, min_units, sec_tens, sec_units}; feeds the timer load data.
- loadn  output  1  active-low load strobe to the timer.
- en  output  1  count enable to the timer.
- digits  output  3  number of digits entered, 0..4.
- done  output  1  one-cycle pulse when the cook cycle ends.
- error  output  1  one-cycle pulse when a start is rejected.

## Operation
- FSM states:
  - ENTRY (reset state)
  - LOAD
  - RUNNING
  - CLEAR
- All outputs are registered or decoded from registered state. There is no combinational path from inputs to outputs.
- Key detection:
  - key_q holds the previous cycle's keypad value.
  - A press is accepted when keypad is exactly one-hot and key_q == 0.
  - Multi-key patterns, held keys and releases are ignored.
- ENTRY, accepted press of key k when digits < 4:
  - data <= {data[11:0], k}; digits increments.
  - With digits == 4, presses are ignored and the buffer is unchanged.
- ENTRY, start:
  - Ignored if door_closed == 0 or data == 0.
  - Rejected if data[7:4] > 5: error pulses, state stays ENTRY, buffer is kept.
  - Otherwise the FSM goes to LOAD.
- LOAD (exactly 1 cycle):
  - loadn = 0, en = 0, data stable; the timer captures data at the exiting edge.
  - Then the FSM goes to RUNNING.
- RUNNING:
  - en = door_closed (registered); opening the door pauses the count without leaving the state.
  - Keys and start are ignored.
  - timer_zero == 1: goes to ENTRY, done pulses, data and digits are cleared, en = 0.
- Cancel:
  - In ENTRY: clears data and digits.
  - In RUNNING: clears data and digits, then goes to CLEAR.
  - In LOAD: ignored; the load completes.
- CLEAR (1 cycle): loadn = 0 with data = 0, en = 0, so the timer is zeroed. Then the FSM goes to ENTRY; done does not pulse.
- Priority within a cycle: cancel > timer_zero > start > key.
- Reset values: state ENTRY, data 0, loadn 1, en 0, digits 0, done 0, error 0, key_q 0.

## Timing
- Key accepted at edge N: data and digits are updated after edge N (latency 1).
- Start accepted at edge S:
  - loadn = 0 during cycle S..S+1, and the timer loads at edge S+1.
  - en = 1 from after edge S+1 if the door is closed.
- loadn and en are never both active in the same cycle.
- loadn low lasts exactly one cycle per LOAD or CLEAR.
- timer_zero sampled high at edge Z in RUNNING: en = 0 and done = 1 after Z; done is back to 0 after Z+1.
- door_closed falling at edge D: en = 0 after D.
- error pulses for exactly one cycle, after the rejecting edge.
- clr asserted at any time (including mid-RUNNING or LOAD): all outputs go to reset values immediately and asynchronously; en drops without waiting for a clock.

## Test plan
- Entry/shift: press 1, 3, 0, 5 (each released between presses) -> data = 16'h1305, digits = 4. A fifth key press 7 -> data unchanged.
- Held and double keys: hold key 2 for 5 cycles -> one digit only. Press keys 2 and 4 together -> ignored, digits unchanged.
- Start and load: data = 16'h0130, start -> loadn low for exactly 1 cycle with en = 0, then en = 1. Drive timer_zero = 1 -> done pulse for 1 cycle, data = 0, en = 0.
- Rejection:
  - data = 16'h0075 with start -> error pulse, state stays ENTRY, buffer kept.
  - data = 0 with start -> no error, no load.
  - door_closed = 0 with valid data and start -> ignored.
- Pause and cancel: in RUNNING, door_closed = 0 -> en = 0 after 1 edge, and en returns with the door. Then cancel -> CLEAR: loadn low 1 cycle with data = 0, no done, back in ENTRY.
- Priority and reset: cancel and start in the same ENTRY cycle -> buffer cleared, no LOAD. clr mid-RUNNING -> en = 0 and loadn = 1 asynchronously, all outputs at reset values.
